pc_watchdog_monitor: RTL and testbench
======================================

# pc_watchdog_monitor

Synthesizable, parametrised successor to the simulation-only clock/reset/PC-capture harness. It sits outside the RV32IM core and owns the core reset: it holds the core in reset after power-up, samples the fetch PC, and keeps a ring buffer of the last distinct PCs for debug readout. It detects a halt (PC self-loop) and a hang (no valid PC for too long), and on a hang can automatically re-reset the core.

## Interface
Parameters:
- ADDR_W, 32: PC width, matching `SramAddrBus`.
- HIST_DEPTH, 8: number of history entries; power of two, at least 2.
- STALL_LIMIT, 16: threshold for both the repeat count and the idle count; at least 2.
- RST_PULSE, 4: number of cycles `core_rst_o` is held high per reset sequence; at least 1.
- AUTO_RESTART, 1: 1 means a timeout re-enters reset; 0 means it parks in FAULT.

Ports:
- clk  in  1  single clock, all logic on its rising edge.
- rst  in  1  reset, synchronous and active-high.
- pc_i  in  ADDR_W  core fetch PC.
- pc_valid_i  in  1  `pc_i` is meaningful this cycle.
- hist_rd_idx_i  in  log2(HIST_DEPTH)  history index; 0 is the most recent entry.
- hist_rd_pc_o  out  ADDR_W  registered history readout.
- hist_cnt_o  out  log2(HIST_DEPTH)+1  number of valid entries, saturating at HIST_DEPTH.
- core_rst_o  out  1  active-high reset to the core.
- halted_o  out  1  sticky halt flag.
- timeout_o  out  1  one-cycle pulse on a hang.
- fault_o  out  1  sticky flag, raised only in FAULT.
- cycle_cnt_o  out  32  cycles spent in RUN, saturating at all ones.
- restart_cnt_o  out  8  timeout count, saturating at 255.

## Operation
States are RESET_HOLD, RUN, HALTED, TIMEOUT and FAULT.
- **RESET_HOLD:** `core_rst_o` is 1. A hold counter counts RST_PULSE cycles, then the state goes to RUN. `cycle_cnt_o`, the repeat count, the idle count and `first_flag` are cleared. History is kept.
- **RUN:** `core_rst_o` is 0 and `cycle_cnt_o` increments every cycle.
  - On a cycle with `pc_valid_i`=1:
    - The idle count is cleared.
    - If `first_flag` is set or `pc_i` differs from the last sample: push `pc_i` into history, clear the repeat count and clear `first_flag`.
    - Otherwise the repeat count increments.
  - On a cycle with `pc_valid_i`=0: the idle count increments.
  - When the repeat count reaches STALL_LIMIT-1, the state goes to HALTED.
  - When the idle count reaches STALL_LIMIT-1, the state goes to TIMEOUT.
- **HALTED:** `halted_o` is 1 and `core_rst_o` is 0. The state is left only by `rst`.
- **TIMEOUT:** lasts exactly one cycle. `timeout_o` is 1 and `restart_cnt_o` increments. The next state is RESET_HOLD if AUTO_RESTART is 1, otherwise FAULT.
- **FAULT:** `fault_o` is 1 and `core_rst_o` is 1 (core kept in reset). The state is left only by `rst`.
- **History:** a ring buffer with a write pointer. A push writes at the write pointer, then increments it, wrapping modulo HIST_DEPTH. The read address is (write pointer − 1 − `hist_rd_idx_i`) mod HIST_DEPTH. Entries at or beyond `hist_cnt_o` read as 0.
- **Arithmetic:** all counters saturate; none wrap. The PC compare is over the full ADDR_W bits.

## Timing
- **During `rst`:** state goes to RESET_HOLD and the hold counter is cleared. History, write pointer, `hist_cnt_o`, `restart_cnt_o`, `cycle_cnt_o`, `halted_o` and `fault_o` all go to 0. `core_rst_o` is 1 and `timeout_o` is 0. `hist_rd_pc_o` is 0.
- **Reset release:** `core_rst_o` stays high for RST_PULSE cycles after the first cycle `rst` is low. RUN starts on the following edge.
- **Halt:** `halted_o` rises on the edge after the STALL_LIMIT-th consecutive identical valid sample. That is the first sample plus STALL_LIMIT-1 repeats.
- **Hang:** `timeout_o` pulses on the edge after STALL_LIMIT consecutive invalid cycles in RUN. With AUTO_RESTART=1, `core_rst_o` rises on the next edge.
- **Simultaneous limits:** a valid sample wins over the idle limit on the same cycle.
- **Readout:** `hist_rd_pc_o` has one cycle of latency. A push and a read in the same cycle return the pre-push contents.
- **`rst` mid-operation:** `rst` overrides every state, including HALTED and FAULT, on the same edge.

## Structure
- Shared package `mon_pkg` holds:
  - the state enum/localparams (3-bit encoding);
  - `CNT_W` = 32 and `RCNT_W` = 8;
  - a clog2 function for index widths.
- Sub-module `pc_hist_ring` (parameters ADDR_W and HIST_DEPTH) contains:
  - the storage array and write pointer;
  - the `hist_cnt` counter;
  - the registered read port.
- The FSM, the repeat/idle counters and the statistics counters stay in the top module.

## Test plan
- **Power-up:** `rst` high for 3 cycles, then low; RST_PULSE=4. `core_rst_o` is 1 for exactly 4 cycles after release, then 0, and `cycle_cnt_o` starts counting from 0.
- **History order:** valid PCs 0x00, 0x04, 0x08 then 0x0C. With idx=0..3, `hist_rd_pc_o` reads 0x0C, 0x08, 0x04, 0x00 (one cycle late) and `hist_cnt_o`=4. Pushing 10 distinct PCs with HIST_DEPTH=8 leaves `hist_cnt_o`=8 and idx 7 returning the third PC.
- **Halt:** after 0x10, drive 0x14 valid for 16 cycles with STALL_LIMIT=16. `halted_o`=1 on the next edge and `core_rst_o` stays 0. Only `rst` clears `halted_o`.
- **Hang with auto-restart:** in RUN, hold `pc_valid_i`=0 for 16 cycles. One `timeout_o` pulse, `restart_cnt_o`=1, then `core_rst_o` high for 4 cycles, then RUN again with history intact.
- **Hang without auto-restart:** AUTO_RESTART=0 with the same stimulus. `fault_o`=1 and `core_rst_o`=1 stay set indefinitely; asserting `rst` returns to RESET_HOLD with all counters at 0.
- **Tie-break:** valid `pc_i` arrives on the cycle the idle count hits its limit. No timeout occurs, and the idle count reads 0 the next cycle.

Source files
------------

// File: rtl/pc_watchdog_monitor_pkg.sv
// Shared types and widths for the PC watchdog monitor and its history ring.
package mon_pkg;
  localparam int CNT_W  = 32;
  localparam int RCNT_W = 8;

  typedef enum logic [2:0] {
    S_RESET_HOLD = 3'd0,
    S_RUN        = 3'd1,
    S_HALTED     = 3'd2,
    S_TIMEOUT    = 3'd3,
    S_FAULT      = 3'd4
  } mon_state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/pc_watchdog_monitor_if.sv
// Core-facing PC sample bus, history readout and watchdog status.
interface pc_watchdog_monitor_if #(
  parameter int ADDR_W     = 32,
  parameter int HIST_DEPTH = 8
);
  import mon_pkg::*;
  localparam int IDX_W = clog2(HIST_DEPTH);

  logic [ADDR_W-1:0] pc_i;
  logic              pc_valid_i;
  logic [IDX_W-1:0]  hist_rd_idx_i;
  logic [ADDR_W-1:0] hist_rd_pc_o;
  logic [IDX_W:0]    hist_cnt_o;
  logic              core_rst_o;
  logic              halted_o;
  logic              timeout_o;
  logic              fault_o;
  logic [CNT_W-1:0]  cycle_cnt_o;
  logic [RCNT_W-1:0] restart_cnt_o;

  modport master (
    output pc_i, pc_valid_i, hist_rd_idx_i,
    input  hist_rd_pc_o, hist_cnt_o, core_rst_o, halted_o, timeout_o, fault_o,
           cycle_cnt_o, restart_cnt_o
  );
  modport slave (
    input  pc_i, pc_valid_i, hist_rd_idx_i,
    output hist_rd_pc_o, hist_cnt_o, core_rst_o, halted_o, timeout_o, fault_o,
           cycle_cnt_o, restart_cnt_o
  );
endinterface

// File: rtl/pc_hist_ring.sv
// Ring buffer of the most recent distinct PCs with a registered, newest-first read port.
module pc_hist_ring import mon_pkg::*; #(
  parameter int ADDR_W     = 32,
  parameter int HIST_DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push_i,
  input  logic [ADDR_W-1:0]            push_pc_i,
  input  logic [clog2(HIST_DEPTH)-1:0] rd_idx_i,
  output logic [ADDR_W-1:0]            rd_pc_o,
  output logic [clog2(HIST_DEPTH):0]   cnt_o
);
  localparam int IDX_W = clog2(HIST_DEPTH);

  logic [ADDR_W-1:0] mem [HIST_DEPTH];
  logic [IDX_W-1:0]  wp;
  logic [IDX_W:0]    cnt;
  logic [IDX_W-1:0]  rd_addr;

  // Index 0 is the entry just behind the write pointer; wraps mod depth.
  assign rd_addr = wp - IDX_W'(1) - rd_idx_i;
  assign cnt_o   = cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      wp      <= '0;
      cnt     <= '0;
      rd_pc_o <= '0;
      for (int i = 0; i < HIST_DEPTH; i++) mem[i] <= '0;
    end else begin
      rd_pc_o <= ({1'b0, rd_idx_i} < cnt) ? mem[rd_addr] : '0;
      if (push_i) begin
        mem[wp] <= push_pc_i;
        wp      <= wp + IDX_W'(1);
        if (cnt != (IDX_W+1)'(HIST_DEPTH)) cnt <= cnt + (IDX_W+1)'(1);
      end
    end
  end
endmodule

// File: rtl/pc_watchdog_monitor.sv
// Owns the core reset; detects PC self-loop (halt) and missing PCs (hang), optionally re-resetting.
module pc_watchdog_monitor import mon_pkg::*; #(
  parameter int ADDR_W       = 32,
  parameter int HIST_DEPTH   = 8,
  parameter int STALL_LIMIT  = 16,
  parameter int RST_PULSE    = 4,
  parameter int AUTO_RESTART = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  pc_watchdog_monitor_if.slave mon
);
  localparam int SL_W   = clog2(STALL_LIMIT) + 1;
  localparam int HOLD_W = clog2(RST_PULSE) + 1;

  mon_state_e        state_q, state_d;
  logic [HOLD_W-1:0] hold_q;
  logic [SL_W-1:0]   rep_q, idle_q;
  logic              first_q, same, push;
  logic [ADDR_W-1:0] last_pc_q;
  logic [CNT_W-1:0]  cycle_q;
  logic [RCNT_W-1:0] restart_q;
  logic [ADDR_W-1:0] rd_pc;
  logic [clog2(HIST_DEPTH):0] hcnt;

  assign same = !first_q && (mon.pc_i == last_pc_q);

  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    unique case (state_q)
      S_RESET_HOLD: if (hold_q == HOLD_W'(RST_PULSE-1)) state_d = S_RUN;
      S_RUN: begin
        // A valid sample always clears idle, so it beats the idle limit.
        if (mon.pc_valid_i) begin
          push = !same;
          if (same && rep_q == SL_W'(STALL_LIMIT-2)) state_d = S_HALTED;
        end else if (idle_q == SL_W'(STALL_LIMIT-1)) begin
          state_d = S_TIMEOUT;
        end
      end
      S_TIMEOUT: state_d = (AUTO_RESTART != 0) ? S_RESET_HOLD : S_FAULT;
      S_HALTED:  state_d = S_HALTED;
      S_FAULT:   state_d = S_FAULT;
      default:   state_d = S_RESET_HOLD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_RESET_HOLD;
      hold_q    <= '0;
      rep_q     <= '0;
      idle_q    <= '0;
      first_q   <= 1'b1;
      last_pc_q <= '0;
      cycle_q   <= '0;
      restart_q <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= '0;
      case (state_q)
        S_RESET_HOLD: begin
          hold_q  <= hold_q + HOLD_W'(1);
          cycle_q <= '0;
          rep_q   <= '0;
          idle_q  <= '0;
          first_q <= 1'b1;
        end
        S_RUN: begin
          if (cycle_q != '1) cycle_q <= cycle_q + CNT_W'(1);
          if (mon.pc_valid_i) begin
            idle_q    <= '0;
            last_pc_q <= mon.pc_i;
            if (push) begin
              rep_q   <= '0;
              first_q <= 1'b0;
            end else if (rep_q != '1) begin
              rep_q <= rep_q + SL_W'(1);
            end
          end else if (idle_q != '1) begin
            idle_q <= idle_q + SL_W'(1);
          end
        end
        S_TIMEOUT: if (restart_q != '1) restart_q <= restart_q + RCNT_W'(1);
        default: ;
      endcase
    end
  end

  pc_hist_ring #(.ADDR_W(ADDR_W), .HIST_DEPTH(HIST_DEPTH)) u_ring (
    .clk       (clk),
    .rst       (rst),
    .push_i    (push),
    .push_pc_i (mon.pc_i),
    .rd_idx_i  (mon.hist_rd_idx_i),
    .rd_pc_o   (rd_pc),
    .cnt_o     (hcnt)
  );

  assign mon.hist_rd_pc_o  = rd_pc;
  assign mon.hist_cnt_o    = hcnt;
  assign mon.core_rst_o    = (state_q == S_RESET_HOLD) || (state_q == S_FAULT);
  assign mon.halted_o      = (state_q == S_HALTED);
  assign mon.timeout_o     = (state_q == S_TIMEOUT);
  assign mon.fault_o       = (state_q == S_FAULT);
  assign mon.cycle_cnt_o   = cycle_q;
  assign mon.restart_cnt_o = restart_q;
endmodule

// File: tb/tb_pc_watchdog_monitor.sv
// Directed bench: one auto-restart instance (ifa) and one fault-parking instance (ifb), same stimulus.
module tb_pc_watchdog_monitor;
  import mon_pkg::*;
  localparam int AW = 32;
  localparam int HD = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] pc  = '0;
  logic          vld = 1'b0;
  logic [2:0]    idx = '0;
  int vec  = 0;
  int errs = 0;

  always #5 clk = ~clk;

  pc_watchdog_monitor_if #(.ADDR_W(AW), .HIST_DEPTH(HD)) ifa ();
  pc_watchdog_monitor_if #(.ADDR_W(AW), .HIST_DEPTH(HD)) ifb ();

  assign ifa.pc_i = pc;  assign ifa.pc_valid_i = vld;  assign ifa.hist_rd_idx_i = idx;
  assign ifb.pc_i = pc;  assign ifb.pc_valid_i = vld;  assign ifb.hist_rd_idx_i = idx;

  pc_watchdog_monitor #(.ADDR_W(AW), .HIST_DEPTH(HD), .STALL_LIMIT(16), .RST_PULSE(4),
                        .AUTO_RESTART(1)) u_dut (.clk(clk), .rst(rst), .mon(ifa.slave));
  pc_watchdog_monitor #(.ADDR_W(AW), .HIST_DEPTH(HD), .STALL_LIMIT(16), .RST_PULSE(4),
                        .AUTO_RESTART(0)) u_dut0 (.clk(clk), .rst(rst), .mon(ifb.slave));

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Leaves rst low at a negedge; four more steps land in RUN.
  task automatic go_reset();
    rst = 1'b1; vld = 1'b0; pc = '0; idx = '0;
    step(3);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; vld = 1'b0; pc = '0; idx = '0;
    step(3);
    vec++;
    if (ifa.core_rst_o !== 1'b1 || ifa.timeout_o !== 1'b0 || ifa.halted_o !== 1'b0 || ifa.fault_o !== 1'b0) begin
      errs++; $display("FAIL reset_flags: got rst/to/halt/fault=%b%b%b%b want 1000",
                       ifa.core_rst_o, ifa.timeout_o, ifa.halted_o, ifa.fault_o);
    end
    vec++;
    if (ifa.hist_cnt_o !== 0 || ifa.hist_rd_pc_o !== 0 || ifa.cycle_cnt_o !== 0 || ifa.restart_cnt_o !== 0) begin
      errs++; $display("FAIL reset_counters: got cnt=%0d rd=%h cyc=%0d rs=%0d want all 0",
                       ifa.hist_cnt_o, ifa.hist_rd_pc_o, ifa.cycle_cnt_o, ifa.restart_cnt_o);
    end
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      vec++;
      if (ifa.core_rst_o !== 1'b1) begin
        errs++; $display("FAIL release_hold[%0d]: got core_rst=%b want 1", k, ifa.core_rst_o);
      end
      step(1);
    end
    vec++;
    if (ifa.core_rst_o !== 1'b0 || ifa.cycle_cnt_o !== 0) begin
      errs++; $display("FAIL run_entry: got core_rst=%b cyc=%0d want 0 0", ifa.core_rst_o, ifa.cycle_cnt_o);
    end
    step(3);
    vec++;
    if (ifa.cycle_cnt_o !== 3) begin
      errs++; $display("FAIL cycle_count: got %0d want 3", ifa.cycle_cnt_o);
    end
  endtask

  task automatic test_history();
    logic [AW-1:0] want;
    go_reset(); step(4);
    vld = 1'b1;
    for (int i = 0; i < 4; i++) begin pc = AW'(i * 4); step(1); end
    vld = 1'b0;
    vec++;
    if (ifa.hist_cnt_o !== 4) begin
      errs++; $display("FAIL hist_cnt4: got %0d want 4", ifa.hist_cnt_o);
    end
    for (int i = 0; i < 5; i++) begin
      idx = 3'(i);
      step(1);
      want = (i < 4) ? AW'(12 - 4 * i) : '0;
      vec++;
      if (ifa.hist_rd_pc_o !== want) begin
        errs++; $display("FAIL hist_read[%0d]: got %h want %h", i, ifa.hist_rd_pc_o, want);
      end
    end
    go_reset(); step(4);
    vld = 1'b1;
    for (int i = 0; i < 10; i++) begin pc = AW'(32'h100 + 4 * i); step(1); end
    vld = 1'b0;
    vec++;
    if (ifa.hist_cnt_o !== 8) begin
      errs++; $display("FAIL hist_cnt_sat: got %0d want 8", ifa.hist_cnt_o);
    end
    idx = 3'd7; step(1);
    vec++;
    if (ifa.hist_rd_pc_o !== 32'h108) begin
      errs++; $display("FAIL hist_oldest: got %h want 00000108", ifa.hist_rd_pc_o);
    end
    idx = 3'd0; step(1);
    vec++;
    if (ifa.hist_rd_pc_o !== 32'h124) begin
      errs++; $display("FAIL hist_newest: got %h want 00000124", ifa.hist_rd_pc_o);
    end
  endtask

  task automatic test_halt();
    logic seen;
    go_reset(); step(4);
    vld = 1'b1; pc = 32'h10; step(1);
    pc = 32'h14; step(15);
    vec++;
    if (ifa.halted_o !== 1'b0) begin
      errs++; $display("FAIL halt_early: got halted=%b want 0", ifa.halted_o);
    end
    step(1);
    vec++;
    if (ifa.halted_o !== 1'b1 || ifa.core_rst_o !== 1'b0 || ifa.timeout_o !== 1'b0) begin
      errs++; $display("FAIL halt_rise: got halt/rst/to=%b%b%b want 100",
                       ifa.halted_o, ifa.core_rst_o, ifa.timeout_o);
    end
    vld = 1'b0; seen = 1'b0;
    for (int k = 0; k < 20; k++) begin step(1); if (ifa.timeout_o) seen = 1'b1; end
    vec++;
    if (ifa.halted_o !== 1'b1 || seen !== 1'b0 || ifa.core_rst_o !== 1'b0) begin
      errs++; $display("FAIL halt_sticky: got halt=%b timeout_seen=%b rst=%b want 1 0 0",
                       ifa.halted_o, seen, ifa.core_rst_o);
    end
    rst = 1'b1; step(1);
    vec++;
    if (ifa.halted_o !== 1'b0 || ifa.core_rst_o !== 1'b1) begin
      errs++; $display("FAIL halt_clear: got halt=%b rst=%b want 0 1", ifa.halted_o, ifa.core_rst_o);
    end
    rst = 1'b0;
  endtask

  task automatic test_hang();
    go_reset(); step(4);
    vld = 1'b1; pc = 32'h40; step(1);
    vld = 1'b0; step(15);
    vec++;
    if (ifa.timeout_o !== 1'b0 || ifb.timeout_o !== 1'b0) begin
      errs++; $display("FAIL hang_early: got to a/b=%b%b want 00", ifa.timeout_o, ifb.timeout_o);
    end
    step(1);
    vec++;
    if (ifa.timeout_o !== 1'b1 || ifb.timeout_o !== 1'b1) begin
      errs++; $display("FAIL hang_pulse: got to a/b=%b%b want 11", ifa.timeout_o, ifb.timeout_o);
    end
    step(1);
    vec++;
    if (ifa.timeout_o !== 1'b0 || ifa.restart_cnt_o !== 1 || ifa.core_rst_o !== 1'b1) begin
      errs++; $display("FAIL auto_restart: got to=%b rs=%0d rst=%b want 0 1 1",
                       ifa.timeout_o, ifa.restart_cnt_o, ifa.core_rst_o);
    end
    vec++;
    if (ifb.fault_o !== 1'b1 || ifb.core_rst_o !== 1'b1 || ifb.restart_cnt_o !== 1) begin
      errs++; $display("FAIL fault_entry: got fault=%b rst=%b rs=%0d want 1 1 1",
                       ifb.fault_o, ifb.core_rst_o, ifb.restart_cnt_o);
    end
    for (int k = 1; k < 4; k++) begin
      step(1);
      vec++;
      if (ifa.core_rst_o !== 1'b1) begin
        errs++; $display("FAIL restart_hold[%0d]: got core_rst=%b want 1", k, ifa.core_rst_o);
      end
    end
    step(1);
    vec++;
    if (ifa.core_rst_o !== 1'b0 || ifa.cycle_cnt_o !== 0 || ifa.hist_cnt_o !== 1) begin
      errs++; $display("FAIL rerun: got rst=%b cyc=%0d hcnt=%0d want 0 0 1",
                       ifa.core_rst_o, ifa.cycle_cnt_o, ifa.hist_cnt_o);
    end
    idx = 3'd0; step(1);
    vec++;
    if (ifa.hist_rd_pc_o !== 32'h40) begin
      errs++; $display("FAIL hist_kept: got %h want 00000040", ifa.hist_rd_pc_o);
    end
    step(20);
    vec++;
    if (ifb.fault_o !== 1'b1 || ifb.core_rst_o !== 1'b1 || ifb.restart_cnt_o !== 1) begin
      errs++; $display("FAIL fault_sticky: got fault=%b rst=%b rs=%0d want 1 1 1",
                       ifb.fault_o, ifb.core_rst_o, ifb.restart_cnt_o);
    end
    rst = 1'b1; step(1);
    vec++;
    if (ifb.fault_o !== 1'b0 || ifb.core_rst_o !== 1'b1 || ifb.restart_cnt_o !== 0 ||
        ifb.cycle_cnt_o !== 0 || ifb.hist_cnt_o !== 0) begin
      errs++; $display("FAIL fault_clear: got fault=%b rst=%b rs=%0d cyc=%0d hcnt=%0d want 0 1 0 0 0",
                       ifb.fault_o, ifb.core_rst_o, ifb.restart_cnt_o, ifb.cycle_cnt_o, ifb.hist_cnt_o);
    end
    rst = 1'b0;
  endtask

  task automatic test_tiebreak();
    logic seen;
    go_reset(); step(4);
    vld = 1'b1; pc = 32'h50; step(1);
    vld = 1'b0; step(15);
    vld = 1'b1; pc = 32'h54; step(1);
    vld = 1'b0;
    vec++;
    if (ifa.timeout_o !== 1'b0 || ifa.hist_cnt_o !== 2) begin
      errs++; $display("FAIL tie_valid_wins: got to=%b hcnt=%0d want 0 2", ifa.timeout_o, ifa.hist_cnt_o);
    end
    seen = 1'b0;
    for (int k = 0; k < 15; k++) begin step(1); if (ifa.timeout_o) seen = 1'b1; end
    vec++;
    if (seen !== 1'b0) begin
      errs++; $display("FAIL tie_idle_cleared: got early timeout=%b want 0", seen);
    end
    step(1);
    vec++;
    if (ifa.timeout_o !== 1'b1) begin
      errs++; $display("FAIL tie_hang_after: got to=%b want 1", ifa.timeout_o);
    end
  endtask

  initial begin
    test_reset();
    test_history();
    test_halt();
    test_hang();
    test_tiebreak();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time bound");
    $fatal(1);
  end
endmodule
